alu_shift_sequencer: RTL and testbench

ALU_SHIFT_SEQUENCER -- requirements
Module: alu_shift_sequencer

---
 rtl/alu_shift_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_shift_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift/rotate sequencer: steps an external single-bit shift ALU shamt times.
// Optional abort input enabled by defining SHIFT_SEQ_ABORT_EN.
module alu_shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic        abort,
`endif
    input  logic [3:0]  op,
    input  logic [31:0] operand,
    input  logic [4:0]  shamt,
    output logic [31:0] alu_a,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SH_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [OP_W-1:0]   opreg;
    logic [SH_W-1:0]   cnt;
    logic              op_legal_c;

    // Opcodes the attached ALU implements as single-bit shifts/rotates
    always_comb begin
        op_legal_c = 1'b0;
        case (op)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: op_legal_c = 1'b1;
            default:                                     op_legal_c = 1'b0;
        endcase
    end

    assign alu_a  = acc;
    assign alu_op = opreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            opreg  <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!op_legal_c) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                            zero   <= 1'b1;
                            err    <= 1'b1;
                        end else if (shamt == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= operand;
                            zero   <= (operand == '0);
                            err    <= 1'b0;
                        end else begin
                            state <= RUN;
                            acc   <= operand;
                            opreg <= op;
                            cnt   <= shamt;
                            err   <= 1'b0;
                        end
                    end
                end
                RUN: begin
`ifdef SHIFT_SEQ_ABORT_EN
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else
`endif
                    begin
                        acc <= alu_out;
                        cnt <= cnt - SH_W'(1);
                        // Last iteration: the ALU output is the final result
                        if (cnt == SH_W'(1)) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= alu_out;
                            zero   <= (alu_out == '0);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer with a single-bit shift ALU model
// and a whole-shift reference model; define SHIFT_SEQ_ABORT_EN to cover abort.
module tb_alu_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] alu_a;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        err;
`ifdef SHIFT_SEQ_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;

    alu_shift_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .alu_a   (alu_a),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team ALU: one-bit shift/rotate of A selected by Op
    always_comb begin
        case (alu_op)
            4'b1000: alu_out = {alu_a[31], alu_a[31:1]};
            4'b1001: alu_out = {alu_a[30:0], 1'b0};
            4'b1010: alu_out = {1'b0, alu_a[31:1]};
            4'b1100: alu_out = {alu_a[30:0], alu_a[31]};
            4'b1101: alu_out = {alu_a[0], alu_a[31:1]};
            default: alu_out = alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] o);
        return (o == 4'b1000) || (o == 4'b1001) || (o == 4'b1010) ||
               (o == 4'b1100) || (o == 4'b1101);
    endfunction

    // Whole shift computed in one step from the opcode definition
    function automatic logic [31:0] ref_shift(input logic [3:0] o, input logic [31:0] v,
                                              input logic [4:0] s);
        int k;
        k = int'(s);
        if (!is_legal(o)) return 32'h0;
        if (k == 0) return v;
        case (o)
            4'b1000: return 32'($signed(v) >>> k);
            4'b1001: return v << k;
            4'b1010: return v >> k;
            4'b1100: return (v << k) | (v >> (32 - k));
            default: return (v >> k) | (v << (32 - k));
        endcase
    endfunction

    // pulse_at > 0: re-pulse start at that cycle; pulse_at < 0: hold start high throughout
    task automatic run_op(input logic [3:0] o, input logic [31:0] v, input logic [4:0] s,
                          input int pulse_at);
        logic [31:0] exp_res;
        int          exp_lat;
        int          n;
        exp_res = ref_shift(o, v, s);
        exp_lat = (!is_legal(o) || s == 5'd0) ? 1 : int'(s) + 1;
        @(negedge clk);
        start = 1'b1; op = o; operand = v; shamt = s;
        @(posedge clk);
        #1;
        n = 1;
        op = 4'($urandom); operand = $urandom; shamt = 5'($urandom);
        start = (pulse_at < 0);
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            start = (pulse_at < 0) || (n == pulse_at);
            op = 4'($urandom); operand = $urandom;
        end
        check("timeout", 32'(done), 32'd1);
        check("latency", 32'(n), 32'(exp_lat));
        check("result", result, exp_res);
        check("zero", 32'(zero), 32'(exp_res == 32'h0));
        check("err", 32'(err), 32'(!is_legal(o)));
        check("busy_done", 32'(busy), 32'd1);
        if (is_legal(o) && s != 5'd0) check("alu_a_final", alu_a, exp_res);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", result, exp_res);
    endtask

    initial begin
        logic [3:0] legal_ops [5];
        logic [31:0] prev;
        int          saw_done;
        legal_ops[0] = 4'b1000; legal_ops[1] = 4'b1001; legal_ops[2] = 4'b1010;
        legal_ops[3] = 4'b1100; legal_ops[4] = 4'b1101;

        reset = 1'b1; start = 1'b0; op = '0; operand = '0; shamt = '0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        #1 reset = 1'b0;

        // Directed cases
        run_op(4'b1001, 32'h0000_0001, 5'd4, 0);
        run_op(4'b1000, 32'h8000_0000, 5'd31, 0);
        run_op(4'b1010, 32'h8000_0000, 5'd31, 0);
        run_op(4'b1101, 32'h0000_0001, 5'd1, 0);
        run_op(4'b1001, 32'h8000_0000, 5'd1, 0);
        run_op(4'b1001, 32'h1234_5678, 5'd0, 0);
        run_op(4'b0000, 32'h1234_5678, 5'd5, 0);
        run_op(4'b1100, 32'hA5A5_0F0F, 5'd8, 2);
        run_op(4'b1101, 32'hDEAD_BEEF, 5'd6, -1);
        run_op(4'b0111, 32'hFFFF_FFFF, 5'd3, -1);

        // Reset at cycle 3 of a shamt-8 run
        @(negedge clk);
        start = 1'b1; op = 4'b1001; operand = 32'h0000_00FF; shamt = 5'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rstrun_busy", 32'(busy), 32'd0);
        check("rstrun_done", 32'(done), 32'd0);
        check("rstrun_result", result, 32'h0);
        check("rstrun_zero", 32'(zero), 32'd1);
        check("rstrun_alu_a", alu_a, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        saw_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done) saw_done++;
        end
        check("rstrun_no_done", 32'(saw_done), 32'd0);
        // First edge after a release accepts a start
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        run_op(4'b1010, 32'hF000_0000, 5'd3, 0);

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort at cycle 3 of a shamt-10 run keeps the previous result
        prev = result;
        @(negedge clk);
        start = 1'b1; op = 4'b1001; operand = 32'h0000_0003; shamt = 5'd10;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, prev);
        saw_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) saw_done++;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_result_hold", result, prev);
        run_op(4'b1101, 32'h0000_0010, 5'd4, 0);
`else
        prev = 32'h0;
`endif

        // Randomized operations, occasionally illegal opcodes or busy-time starts
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ro;
            int         pa;
            ro = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
            pa = ($urandom_range(0, 3) == 0) ? -1 : 0;
            run_op(ro, $urandom, 5'($urandom), pa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
